// File: rtl/run_step_ctrl_if.sv
// rtl/run_step_ctrl_if.sv - signal bundle between the run switch front end and the CPU step logic
//
// Purpose: carries the run/step controls toward run_step_ctrl and its step outputs back.
// Ports (slave = run_step_ctrl side):
//   switch_run   in   raw asynchronous run/step switch
//   auto_mode    in   1 = auto-run while held, 0 = one step per press
//   auto_period  in   idle cycles between auto steps
//   halt         in   suppresses step_en
//   step_en      out  one-cycle CPU advance enable
//   run_stable   out  debounced switch level
//   step_count   out  step_en pulses since reset (wraps)
//   state        out  0 IDLE, 1 STEP, 2 WAIT_REL, 3 AUTO

interface run_step_ctrl_if #(
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 32
) ();
    logic                switch_run;
    logic                auto_mode;
    logic [PERIOD_W-1:0] auto_period;
    logic                halt;
    logic                step_en;
    logic                run_stable;
    logic [CNT_W-1:0]    step_count;
    logic [1:0]          state;

    modport master (
        output switch_run, auto_mode, auto_period, halt,
        input  step_en, run_stable, step_count, state
    );

    modport slave (
        input  switch_run, auto_mode, auto_period, halt,
        output step_en, run_stable, step_count, state
    );
endinterface

// File: rtl/run_step_ctrl.sv
// rtl/run_step_ctrl.sv - turns the raw run switch into clean one-cycle CPU step enables
//
// Purpose: synchronises and debounces switch_run, then issues either one step per press
// (manual) or periodic steps while held (auto). halt suppresses steps; step_count tallies them.
// Ports:
//   fastclk  in  system clock, all logic on posedge
//   reset    in  synchronous active-high reset
//   bus      run_step_ctrl_if.slave (switch_run, auto_mode, auto_period, halt in;
//                                    step_en, run_stable, step_count, state out)

module run_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PERIOD_W        = 16,
    parameter int CNT_W           = 32
) (
    input  logic          fastclk,
    input  logic          reset,
    run_step_ctrl_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STEP     = 2'd1,
        S_WAIT_REL = 2'd2,
        S_AUTO     = 2'd3
    } state_t;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic                run_stable_q, run_stable_d;
    logic                prev_stable_q, prev_stable_d;
    logic                rise_q, rise_d;
    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic                step_en_q, step_en_d;
    logic [CNT_W-1:0]    step_count_q, step_count_d;

    always_comb begin
        sync1_d       = bus.switch_run;
        sync2_d       = sync1_q;
        db_cnt_d      = '0;
        run_stable_d  = run_stable_q;
        prev_stable_d = run_stable_q;
        rise_d        = run_stable_q & ~prev_stable_q;
        state_d       = state_q;
        timer_d       = timer_q;
        step_en_d     = 1'b0;

        // Count consecutive disagreeing samples; the D-th one flips the level.
        if (sync2_q != run_stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                run_stable_d = ~run_stable_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // Release checks look at the level being registered this edge so the FSM
        // leaves on the same edge run_stable falls.
        case (state_q)
            S_IDLE: begin
                if (rise_q) begin
                    if (bus.auto_mode) begin
                        state_d = S_AUTO;
                        if (!bus.halt) begin
                            step_en_d = 1'b1;
                            timer_d   = bus.auto_period;
                        end else begin
                            // Halted on entry: step as soon as halt drops.
                            timer_d = '0;
                        end
                    end else begin
                        state_d   = S_STEP;
                        step_en_d = ~bus.halt;
                    end
                end
            end
            S_STEP: begin
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!run_stable_d) begin
                    state_d = S_IDLE;
                end
            end
            S_AUTO: begin
                if (!run_stable_d) begin
                    state_d = S_IDLE;
                end else if (!bus.auto_mode) begin
                    state_d = S_WAIT_REL;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - PERIOD_W'(1);
                end else if (!bus.halt) begin
                    step_en_d = 1'b1;
                    timer_d   = bus.auto_period;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter moves on the same edge step_en rises, so both are visible together.
        step_count_d = step_count_q + {{(CNT_W-1){1'b0}}, step_en_d};
    end

    always_ff @(posedge fastclk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_cnt_q      <= '0;
            run_stable_q  <= 1'b0;
            prev_stable_q <= 1'b0;
            rise_q        <= 1'b0;
            state_q       <= S_IDLE;
            timer_q       <= '0;
            step_en_q     <= 1'b0;
            step_count_q  <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_cnt_q      <= db_cnt_d;
            run_stable_q  <= run_stable_d;
            prev_stable_q <= prev_stable_d;
            rise_q        <= rise_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            step_en_q     <= step_en_d;
            step_count_q  <= step_count_d;
        end
    end

    assign bus.step_en    = step_en_q;
    assign bus.run_stable = run_stable_q;
    assign bus.step_count = step_count_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_run_step_ctrl.sv
// tb/tb_run_step_ctrl.sv - self-checking bench for run_step_ctrl with a behavioural model

module tb_run_step_ctrl;
    localparam int D  = 16;
    localparam int PW = 16;
    localparam int CW = 4;

    logic fastclk = 1'b0;
    logic reset;

    run_step_ctrl_if #(.PERIOD_W(PW), .CNT_W(CW)) bus ();

    run_step_ctrl #(.DEBOUNCE_CYCLES(D), .PERIOD_W(PW), .CNT_W(CW)) dut (
        .fastclk (fastclk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 fastclk = ~fastclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: raw switch delayed two edges, then a level that flips once the last
    // D delayed samples all disagree with it.
    bit sw_pipe[$];
    bit sync_hist[$];
    bit m_stable, sh2, sh3;
    int m_phase;
    int m_wait;
    bit m_step;
    int m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit sample, new_st, rise, all_diff;
        if (reset) begin
            sw_pipe = '{1'b0, 1'b0};
            sync_hist.delete();
            m_stable = 0; sh2 = 0; sh3 = 0;
            m_phase = 0; m_wait = 0; m_step = 0; m_count = 0;
            return;
        end
        rise   = sh2 && !sh3;
        sample = sw_pipe.pop_front();
        sw_pipe.push_back(bus.switch_run);
        sync_hist.push_back(sample);
        if (sync_hist.size() > D) void'(sync_hist.pop_front());
        new_st = m_stable;
        if (sync_hist.size() == D) begin
            all_diff = 1;
            foreach (sync_hist[i]) if (sync_hist[i] == m_stable) all_diff = 0;
            if (all_diff) new_st = !m_stable;
        end
        sh3 = sh2; sh2 = m_stable; m_stable = new_st;

        m_step = 0;
        case (m_phase)
            0: if (rise) begin
                if (bus.auto_mode) begin
                    m_phase = 3;
                    if (!bus.halt) begin m_step = 1; m_wait = int'(bus.auto_period); end
                    else m_wait = 0;
                end else begin
                    m_phase = 1;
                    m_step  = !bus.halt;
                end
            end
            1: m_phase = 2;
            2: if (!m_stable) m_phase = 0;
            default: begin
                if (!m_stable) m_phase = 0;
                else if (!bus.auto_mode) m_phase = 2;
                else if (m_wait > 0) m_wait--;
                else if (!bus.halt) begin m_step = 1; m_wait = int'(bus.auto_period); end
            end
        endcase
        if (m_step) m_count = (m_count + 1) % (1 << CW);
    endtask

    task automatic compare();
        check("step_en", 64'(bus.step_en), 64'(m_step));
        check("run_stable", 64'(bus.run_stable), 64'(m_stable));
        check("step_count", 64'(bus.step_count), 64'(m_count));
        check("state", 64'(bus.state), 64'(m_phase));
    endtask

    task automatic tick();
        @(posedge fastclk);
        model_step();
        @(negedge fastclk);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.switch_run = 1'b0; bus.auto_mode = 1'b0; bus.halt = 1'b0; bus.auto_period = '0;
        tick(); tick();
        check("rst_step_en", 64'(bus.step_en), 64'd0);
        check("rst_run_stable", 64'(bus.run_stable), 64'd0);
        check("rst_step_count", 64'(bus.step_count), 64'd0);
        check("rst_state", 64'(bus.state), 64'd0);
        reset = 1'b0;
    endtask

    // Ticks until the named output condition holds; reports the tick index or -1.
    task automatic wait_for(input int sel, input int bound, output int at);
        at = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if ((sel == 0 && bus.step_en) || (sel == 1 && bus.state == 2'd0)) begin
                at = i;
                break;
            end
        end
    endtask

    initial begin
        int rs_first, se_first, pulses, at, hold;
        reset = 1'b1;
        bus.switch_run = 1'b0; bus.auto_mode = 1'b0; bus.halt = 1'b0; bus.auto_period = '0;

        // 1: manual press held 100 cycles
        do_reset();
        bus.switch_run = 1'b1;
        rs_first = -1; se_first = -1; pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.run_stable && rs_first < 0) rs_first = i;
            if (bus.step_en) begin pulses++; if (se_first < 0) se_first = i; end
        end
        check("t1_stable_lat", 64'(rs_first), 64'd18);
        check("t1_step_lat", 64'(se_first), 64'd20);
        check("t1_pulses", 64'(pulses), 64'd1);
        check("t1_count", 64'(bus.step_count), 64'd1);
        check("t1_wait_rel", 64'(bus.state), 64'd2);
        bus.switch_run = 1'b0;
        wait_for(1, 40, at);
        check("t1_idle_lat", 64'(at), 64'd18);

        // 2: 10-cycle glitch is filtered
        do_reset();
        bus.switch_run = 1'b1;
        pulses = 0; rs_first = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 11) bus.switch_run = 1'b0;
            tick();
            if (bus.run_stable) rs_first = 1;
            if (bus.step_en) pulses++;
        end
        check("t2_stable", 64'(rs_first), 64'd0);
        check("t2_pulses", 64'(pulses), 64'd0);
        check("t2_count", 64'(bus.step_count), 64'd0);

        // 3: auto mode, period 3
        do_reset();
        bus.auto_mode = 1'b1; bus.auto_period = 16'd3; bus.switch_run = 1'b1;
        wait_for(0, 40, at);
        check("t3_entry_lat", 64'(at), 64'd20);
        check("t3_auto", 64'(bus.state), 64'd3);
        pulses = 1;
        for (int i = 1; i < 40; i++) begin
            tick();
            if (bus.step_en) pulses++;
        end
        check("t3_pulses", 64'(pulses), 64'd10);
        bus.switch_run = 1'b0;
        wait_for(1, 40, at);
        check("t3_idle_lat", 64'(at), 64'd18);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (bus.step_en) pulses++; end
        check("t3_no_more", 64'(pulses), 64'd0);

        // 4: auto period 0 with halt on cycles 5-9
        do_reset();
        bus.auto_mode = 1'b1; bus.auto_period = 16'd0; bus.switch_run = 1'b1;
        wait_for(0, 40, at);
        check("t4_entry_lat", 64'(at), 64'd20);
        for (int c = 1; c <= 15; c++) begin
            bus.halt = (c >= 5 && c <= 9);
            tick();
            check($sformatf("t4_step_c%0d", c), 64'(bus.step_en), (c >= 5 && c <= 9) ? 64'd0 : 64'd1);
        end
        check("t4_count", 64'(bus.step_count), 64'd11);
        bus.halt = 1'b0; bus.switch_run = 1'b0;
        wait_for(1, 40, at);

        // 5: manual press halted, then a clean press
        do_reset();
        bus.halt = 1'b1; bus.switch_run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (bus.step_en) pulses++; end
        check("t5_halted_pulses", 64'(pulses), 64'd0);
        check("t5_halted_count", 64'(bus.step_count), 64'd0);
        check("t5_halted_state", 64'(bus.state), 64'd2);
        bus.switch_run = 1'b0; bus.halt = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        bus.switch_run = 1'b1;
        for (int i = 0; i < 40; i++) begin tick(); if (bus.step_en) pulses++; end
        check("t5_second_pulses", 64'(pulses), 64'd1);
        check("t5_second_count", 64'(bus.step_count), 64'd1);
        bus.switch_run = 1'b0;
        for (int i = 0; i < 25; i++) tick();

        // 6: 16 presses wrap a 4-bit counter, then reset mid-press
        do_reset();
        for (int p = 1; p <= 16; p++) begin
            bus.switch_run = 1'b1;
            for (int i = 0; i < 25; i++) tick();
            bus.switch_run = 1'b0;
            for (int i = 0; i < 25; i++) tick();
            if (p == 15) check("t6_count15", 64'(bus.step_count), 64'd15);
        end
        check("t6_wrap", 64'(bus.step_count), 64'd0);
        bus.switch_run = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        reset = 1'b1;
        tick(); tick();
        check("t6_mid_step_en", 64'(bus.step_en), 64'd0);
        check("t6_mid_stable", 64'(bus.run_stable), 64'd0);
        check("t6_mid_count", 64'(bus.step_count), 64'd0);
        check("t6_mid_state", 64'(bus.state), 64'd0);
        reset = 1'b0;
        wait_for(0, 40, at);
        check("t6_restep_lat", 64'(at), 64'(D + 4));
        pulses = 1;
        for (int i = 0; i < 40; i++) begin tick(); if (bus.step_en) pulses++; end
        check("t6_restep_pulses", 64'(pulses), 64'd1);

        // Random soak against the model
        do_reset();
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                bus.switch_run = ~bus.switch_run;
                hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : $urandom_range(15, 60);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 59) == 0) bus.auto_mode = ~bus.auto_mode;
            if ($urandom_range(0, 29) == 0) bus.auto_period = PW'($urandom_range(0, 5));
            bus.halt = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
